// File: rtl/program_loader.sv
// Serial-byte program loader: writes received bytes to instruction memory while
// assembling 4-byte words, stopping on the halt word or when memory is full.
module program_loader #(
    parameter int                 NB_BYTE    = 8,
    parameter int                 NB_DATA    = 32,
    parameter int                 NB_ADDRESS = 7,
    parameter int                 N_BYTES    = 128,
    parameter logic [NB_DATA-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [NB_BYTE-1:0]    i_rx_data,
    input  logic                  i_rx_valid,
    output logic [NB_BYTE-1:0]    o_write_data,
    output logic                  o_write_enable,
    output logic                  o_loading,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [NB_ADDRESS:0]   o_byte_count,
    output logic [NB_ADDRESS-2:0] o_word_count
);

    // Only the first three bytes of a word need storing; the fourth is the live input.
    localparam int                  PART_W   = NB_DATA - NB_BYTE;
    localparam logic [NB_ADDRESS:0] CAPACITY = (NB_ADDRESS + 1)'(N_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          phase;
    logic [PART_W-1:0]   shift_word;
    logic [NB_DATA-1:0]  word_next;
    logic [NB_ADDRESS:0] byte_count_next;
    logic                accept;
    logic                last_byte;
    logic                halt_hit;
    logic                cap_hit;

    assign accept          = (state == LOAD) && i_rx_valid;
    assign last_byte       = (phase == 2'd3);
    assign word_next       = {shift_word, i_rx_data};
    assign byte_count_next = o_byte_count + 1'b1;
    assign halt_hit        = accept && last_byte && (word_next == HALT_WORD);
    assign cap_hit         = accept && (byte_count_next == CAPACITY);

    assign o_loading  = (state == LOAD);
    assign o_done     = (state == DONE);
    assign o_overflow = (state == ERROR);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Halt is checked before capacity so a halt word ending exactly at the last byte wins.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (halt_hit) begin
                    state_next = DONE;
                end else if (cap_hit) begin
                    state_next = ERROR;
                end
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_write_enable <= 1'b0;
            o_write_data   <= '0;
            o_byte_count   <= '0;
            o_word_count   <= '0;
            phase          <= '0;
            shift_word     <= '0;
        end else begin
            o_write_enable <= accept;
            if (accept) begin
                o_write_data <= i_rx_data;
                o_byte_count <= byte_count_next;
                shift_word   <= word_next[PART_W-1:0];
                if (last_byte) begin
                    phase        <= '0;
                    o_word_count <= o_word_count + 1'b1;
                end else begin
                    phase <= phase + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised scoreboard bench for program_loader against a queue-based reference model.
module tb_program_loader;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic [7:0] o_write_data;
    logic       o_write_enable;
    logic       o_loading;
    logic       o_done;
    logic       o_overflow;
    logic [7:0] o_byte_count;
    logic [5:0] o_word_count;

    program_loader dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_write_data   (o_write_data),
        .o_write_enable (o_write_enable),
        .o_loading      (o_loading),
        .o_done         (o_done),
        .o_overflow     (o_overflow),
        .o_byte_count   (o_byte_count),
        .o_word_count   (o_word_count)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [7:0] data;
        int         bytes;
        int         words;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] part[$];
    int         m_mode;   // 0 idle, 1 load, 2 done, 3 error
    int         m_bytes;
    int         m_words;
    logic [7:0] m_last;
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode  = 0;
        m_bytes = 0;
        m_words = 0;
        m_last  = 8'h00;
        part.delete();
    endfunction

    function automatic void model_step(input logic s, input logic v, input logic [7:0] d);
        logic [31:0] w;
        if (m_mode == 0) begin
            if (s) m_mode = 1;
        end else if (m_mode == 1 && v) begin
            m_bytes++;
            m_last = d;
            part.push_back(d);
            if (part.size() == 4) begin
                m_words++;
                w = {part[0], part[1], part[2], part[3]};
                part.delete();
                if (w == 32'hFFFFFFFF) m_mode = 2;
            end
            if (m_mode == 1 && m_bytes == 128) m_mode = 3;
            exp_q.push_back('{data: d, bytes: m_bytes, words: m_words});
        end
    endfunction

    task automatic cycle(input logic s, input logic v, input logic [7:0] d);
        @(negedge i_clock);
        i_start    = s;
        i_rx_valid = v;
        i_rx_data  = d;
        @(posedge i_clock);
        #1;
        model_step(s, v, d);
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
    endtask

    task automatic do_reset(input logic v, input logic [7:0] d);
        @(negedge i_clock);
        i_reset    = 1'b1;
        i_rx_valid = v;
        i_rx_data  = d;
        i_start    = 1'($urandom_range(0, 1));
        @(posedge i_clock);
        #1;
        model_reset();
        mon_en     = 1'b1;
        i_reset    = 1'b0;
        i_rx_valid = 1'b0;
        i_start    = 1'b0;
    endtask

    // Monitor: consumes one expected write per strobe and checks status every cycle.
    always @(negedge i_clock) begin
        exp_t e;
        if (mon_en) begin
            chk("strobe_present", longint'(o_write_enable), longint'(exp_q.size() != 0));
            if (o_write_enable && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_data", longint'(o_write_data), longint'(e.data));
                chk("strobe_byte_count", longint'(o_byte_count), longint'(e.bytes));
                chk("strobe_word_count", longint'(o_word_count), longint'(e.words));
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            chk("hold_data", longint'(o_write_data), longint'(m_last));
            chk("byte_count", longint'(o_byte_count), longint'(m_bytes));
            chk("word_count", longint'(o_word_count), longint'(m_words));
            chk("loading", longint'(o_loading), longint'(m_mode == 1));
            chk("done", longint'(o_done), longint'(m_mode == 2));
            chk("overflow", longint'(o_overflow), longint'(m_mode == 3));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] prog[8];
        logic [7:0] d;
        logic       v;
        logic       s;
        model_reset();
        prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

        do_reset(1'b1, 8'h5A);
        chk("reset_write_enable", longint'(o_write_enable), 0);
        chk("reset_byte_count", longint'(o_byte_count), 0);
        chk("reset_loading", longint'(o_loading), 0);

        // Bytes in IDLE are ignored
        cycle(1'b0, 1'b1, 8'h11);
        cycle(1'b0, 1'b1, 8'h22);
        chk("idle_byte_count", longint'(o_byte_count), 0);
        chk("idle_loading", longint'(o_loading), 0);

        // Short program ending in halt, with random gaps
        cycle(1'b1, 1'b0, 8'h00);
        foreach (prog[i]) begin
            repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0, 8'h00);
            cycle(1'b0, 1'b1, prog[i]);
        end
        chk("prog_word_count", longint'(o_word_count), 2);
        chk("prog_byte_count", longint'(o_byte_count), 8);
        chk("prog_done", longint'(o_done), 1);
        cycle(1'b1, 1'b1, 8'h33);
        chk("done_absorbing", longint'(o_done), 1);

        // Fill memory with zeros to overflow
        do_reset(1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        repeat (128) cycle(1'b0, 1'b1, 8'h00);
        chk("ovf_flag", longint'(o_overflow), 1);
        chk("ovf_word_count", longint'(o_word_count), 32);
        chk("ovf_byte_count", longint'(o_byte_count), 128);
        cycle(1'b0, 1'b1, 8'h44);
        cycle(1'b1, 1'b1, 8'h45);

        // Halt word landing exactly on the last byte
        do_reset(1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        repeat (124) cycle(1'b0, 1'b1, 8'h00);
        repeat (4) cycle(1'b0, 1'b1, 8'hFF);
        chk("edge_halt_done", longint'(o_done), 1);
        chk("edge_halt_overflow", longint'(o_overflow), 0);
        chk("edge_halt_byte_count", longint'(o_byte_count), 128);

        // Reset in the cycle after the second byte, with a byte in flight
        do_reset(1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h01);
        cycle(1'b0, 1'b1, 8'h02);
        do_reset(1'b1, 8'h77);
        chk("abort_write_enable", longint'(o_write_enable), 0);
        chk("abort_write_data", longint'(o_write_data), 0);
        chk("abort_byte_count", longint'(o_byte_count), 0);
        chk("abort_loading", longint'(o_loading), 0);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h03);
        chk("restart_byte_count", longint'(o_byte_count), 1);

        // Start and byte together: byte dropped
        do_reset(1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'hAA);
        cycle(1'b0, 1'b1, 8'hBB);
        chk("drop_byte_count", longint'(o_byte_count), 1);
        chk("drop_write_data", longint'(o_write_data), 8'hBB);

        // Random loads with stray starts, gaps and FF-heavy data
        for (int r = 0; r < 8; r++) begin
            do_reset(1'($urandom_range(0, 1)), 8'($urandom));
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
            for (int k = 0; k < 200; k++) begin
                v = ($urandom_range(0, 2) != 0);
                s = ($urandom_range(0, 15) == 0);
                if (r[0] && $urandom_range(0, 7) != 0) d = 8'hFF;
                else d = 8'($urandom);
                cycle(s, v, d);
            end
        end

        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
